popcount_core: RTL
==================

# popcount_core

Streaming population-count engine that sits directly downstream of the PopCount AXI4-Lite register slave. It consumes 32-bit words that software writes into the slave registers, one word per valid/ready handshake. It accumulates the number of set bits across a packet terminated by `in_last`. It then presents the packet total and the word count in a held result slot that the slave exposes as read-only registers.

## Interface
Parameters:
- DATA_W, 32, input word width; must be a multiple of 8
- CNT_W, 32, width of the bit-count accumulator and the word counter

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- clear  in  1  synchronous flush of pipeline, accumulators and result slot
- in_data  in  DATA_W  word to count
- in_valid  in  1  in_data/in_last valid
- in_last  in  1  word is the final word of a packet
- in_ready  out  1  core accepts a word this cycle
- res_count  out  CNT_W  total set bits of the packet, modulo 2^CNT_W
- res_words  out  CNT_W  number of words in the packet, modulo 2^CNT_W
- res_ovf  out  1  bit or word accumulator wrapped during this packet
- res_valid  out  1  result slot full
- res_ready  in  1  consumer takes the result this cycle
- busy  out  1  a word is in flight, or a packet is partially accumulated

## Operation
- Stage S1 registers the following on an accepted word (`in_valid && in_ready`):
  - per-byte popcounts, DATA_W/8 fields of 4 bits each
  - `s1_last`
  - `s1_valid` = 1
- Stage S2 sums the S1 byte counts into one (clog2(DATA_W)+1)-bit value. It then adds that value to `acc_bits` and increments `acc_words`.
  - Both adds are modulo 2^CNT_W.
  - A carry-out of either add sets the sticky flag `acc_ovf`.
- When S2 retires a word with `s1_last` = 1, the slot loads as follows in the same edge:
  - `res_count` = acc_bits + current, `res_words` = acc_words + 1, `res_ovf` = updated acc_ovf
  - `res_valid` ← 1
  - `acc_bits`, `acc_words` and `acc_ovf` clear to 0
- Advance rule: S1 retires when `s1_valid && (!s1_last || !res_valid || res_ready)`.
- `in_ready` = `!clear && (!s1_valid || advance)`. It is combinational; no dependency on `in_valid`.
- Result consumed: `res_valid && res_ready`. If a new last word retires in the same cycle, the slot reloads and `res_valid` stays 1. Otherwise `res_valid` ← 0.
- While `res_valid` = 1, res_* outputs hold stable.
- Control FSM (`busy` and debug only):
  - IDLE: no S1 word and acc_words = 0
  - ACCUM: S1 word in flight, or acc_words ≠ 0
  - HOLD: S1 holds a last word blocked by a full slot
  - Transitions:
    - IDLE→ACCUM on accept
    - ACCUM→HOLD when blocked
    - HOLD→ACCUM/IDLE on res_ready
    - any state→IDLE on clear or reset
- `busy` = state ≠ IDLE.
- `clear` has priority over everything:
  - s1_valid, acc_*, res_valid and state all go to 0/IDLE
  - a word presented in the same cycle is not accepted (in_ready = 0)

## Timing
- Reset values (asynchronous): in_ready = 1, res_valid = 0, res_count = 0, res_words = 0, res_ovf = 0, busy = 0, s1_valid = 0, acc_* = 0.
- Throughput: one word per cycle with no backpressure.
- Latency: a last word accepted at edge t produces `res_valid` = 1 after edge t+1, i.e. visible in the cycle after the S1→S2 retire.
  - First output-visible cycle is 2 cycles after the `in_valid` cycle.
- Back-to-back packets: a one-word packet every cycle sustains full rate as long as `res_ready` = 1.
- Backpressure: with `res_valid` = 1 and `res_ready` = 0, a last word in S1 stalls and in_ready drops.
  - At most one word (the blocked last) is in flight.
  - Nothing is dropped or duplicated.
- Reset mid-packet: partial accumulation is discarded; the first word after reset starts a new packet.

## Test plan
- Reset, then one word 0xFFFFFFFF with in_last=1 -> res_valid=1 two cycles later, res_count=32, res_words=1, res_ovf=0; busy returns to 0.
- Packet 0x00000001, 0x00000002, 0x00000003, 0x00000004 (last on the 4th), streamed back-to-back -> res_count=5, res_words=4; in_ready stays 1 throughout.
- Hold res_ready=0; send packet A {0x0000000F, last} and then packet B {0x000000FF, last} -> A stays on res_* (count 4) and in_ready drops with B blocked in S1. Raise res_ready for 1 cycle -> B appears (count 8, words 1); no third result.
- Send 0xFFFF0000, 0x0000FFFF without last, then assert clear for one cycle with in_valid=1 on 0xFFFFFFFF -> that word is not accepted and busy=0. Next packet {0x00000003, last} -> res_count=2, res_words=1.
- CNT_W=6: three words 0xFFFFFFFF, last on the third -> res_count=32 (96 mod 64), res_words=3, res_ovf=1. The next packet {0x1, last} -> res_ovf=0.
- Assert reset asynchronously mid-cycle while S1 is full and res_valid=1 -> all outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/popcount_core.sv
// Streaming popcount engine: per-byte counts in S1, packet accumulation in S2,
// and a held result slot that is released by res_ready.
module popcount_core #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [CNT_W-1:0]  res_count,
  output logic [CNT_W-1:0]  res_words,
  output logic              res_ovf,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy
);

  // state | meaning
  // IDLE  | no S1 word and no partially accumulated packet
  // ACCUM | S1 word in flight or packet partially accumulated
  // HOLD  | S1 holds a last word blocked by a full result slot
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int NB    = DATA_W / 8;
  localparam int SUM_W = $clog2(DATA_W) + 1;
  localparam int AW    = ((CNT_W > SUM_W) ? CNT_W : SUM_W) + 1;
  localparam logic [CNT_W:0] ONE_W = 1;

  logic [NB-1:0][3:0] byte_cnt;
  logic [NB-1:0][3:0] s1_bytes_q, s1_bytes_d;
  logic               s1_valid_q, s1_valid_d;
  logic               s1_last_q, s1_last_d;
  logic [CNT_W-1:0]   acc_bits_q, acc_bits_d;
  logic [CNT_W-1:0]   acc_words_q, acc_words_d;
  logic               acc_ovf_q, acc_ovf_d;
  logic [CNT_W-1:0]   res_count_q, res_count_d;
  logic [CNT_W-1:0]   res_words_q, res_words_d;
  logic               res_ovf_q, res_ovf_d;
  logic               res_valid_q, res_valid_d;
  state_t             state_q, state_d;

  logic [SUM_W-1:0]   word_sum;
  logic [AW-1:0]      bits_add;
  logic [CNT_W:0]     words_add;
  logic               ovf_upd;
  logic               advance;
  logic               accept;
  logic               consume;
  logic               blocked;
  logic               pending_d;

  always_comb begin
    byte_cnt = '0;
    for (int b = 0; b < NB; b++) begin
      for (int i = 0; i < 8; i++) begin
        byte_cnt[b] = byte_cnt[b] + {3'd0, in_data[8*b+i]};
      end
    end
  end

  always_comb begin
    word_sum = '0;
    for (int b = 0; b < NB; b++) begin
      word_sum = word_sum + SUM_W'(s1_bytes_q[b]);
    end
  end

  // Wide adds so the carry out of either accumulator is visible.
  assign bits_add  = AW'(acc_bits_q) + AW'(word_sum);
  assign words_add = {1'b0, acc_words_q} + ONE_W;
  assign ovf_upd   = acc_ovf_q | (|bits_add[AW-1:CNT_W]) | words_add[CNT_W];

  assign advance  = s1_valid_q && (!s1_last_q || !res_valid_q || res_ready);
  assign in_ready = !clear && (!s1_valid_q || advance);
  assign accept   = in_valid && in_ready;
  assign consume  = res_valid_q && res_ready;
  assign blocked  = s1_valid_q && s1_last_q && res_valid_q && !res_ready;

  always_comb begin
    s1_bytes_d  = s1_bytes_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    acc_bits_d  = acc_bits_q;
    acc_words_d = acc_words_q;
    acc_ovf_d   = acc_ovf_q;
    res_count_d = res_count_q;
    res_words_d = res_words_q;
    res_ovf_d   = res_ovf_q;
    res_valid_d = res_valid_q;
    if (clear) begin
      s1_valid_d  = 1'b0;
      s1_last_d   = 1'b0;
      acc_bits_d  = '0;
      acc_words_d = '0;
      acc_ovf_d   = 1'b0;
      res_count_d = '0;
      res_words_d = '0;
      res_ovf_d   = 1'b0;
      res_valid_d = 1'b0;
    end else begin
      if (accept) begin
        s1_valid_d = 1'b1;
        s1_last_d  = in_last;
        s1_bytes_d = byte_cnt;
      end else if (advance) begin
        s1_valid_d = 1'b0;
      end
      if (consume) begin
        res_valid_d = 1'b0;
      end
      if (advance) begin
        if (s1_last_q) begin
          res_count_d = bits_add[CNT_W-1:0];
          res_words_d = words_add[CNT_W-1:0];
          res_ovf_d   = ovf_upd;
          res_valid_d = 1'b1;
          acc_bits_d  = '0;
          acc_words_d = '0;
          acc_ovf_d   = 1'b0;
        end else begin
          acc_bits_d  = bits_add[CNT_W-1:0];
          acc_words_d = words_add[CNT_W-1:0];
          acc_ovf_d   = ovf_upd;
        end
      end
    end
  end

  assign pending_d = s1_valid_d || (acc_words_d != '0);

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) state_d = ST_ACCUM;
        end
        ST_ACCUM: begin
          if (blocked)         state_d = ST_HOLD;
          else if (!pending_d) state_d = ST_IDLE;
        end
        ST_HOLD: begin
          if (res_ready) state_d = pending_d ? ST_ACCUM : ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_bytes_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      acc_bits_q  <= '0;
      acc_words_q <= '0;
      acc_ovf_q   <= 1'b0;
      res_count_q <= '0;
      res_words_q <= '0;
      res_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
      state_q     <= ST_IDLE;
    end else begin
      s1_bytes_q  <= s1_bytes_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      acc_bits_q  <= acc_bits_d;
      acc_words_q <= acc_words_d;
      acc_ovf_q   <= acc_ovf_d;
      res_count_q <= res_count_d;
      res_words_q <= res_words_d;
      res_ovf_q   <= res_ovf_d;
      res_valid_q <= res_valid_d;
      state_q     <= state_d;
    end
  end

  assign res_count = res_count_q;
  assign res_words = res_words_q;
  assign res_ovf   = res_ovf_q;
  assign res_valid = res_valid_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
